rotor_stepper: RTL
==================

// Module: rotor_stepper
// PURPOSE
//  Keypress-driven stepping controller for the 3-rotor path. Accepts one letter per keypress
//  and advances the rotor positions Enigma-style (odometer with notches), stepping BEFORE
//  encipherment. Then presents the letter plus the new positions to the rotor chain
//  (rotor 0 = fast/entry rotor) through a valid/ready register stage.
// PARAMETERS
//  NOTCH0     16  position of rotor 0 (fast) at which rotor 1 is kicked on the next step
//  NOTCH1     4   position of rotor 1 (middle) at which rotor 2 is kicked / double-step occurs
//  ALPHA      26  alphabet size; all positions and letters are modulo ALPHA, 5-bit encoded
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  load       in   1  1-cycle strobe: load start positions from load_pos0..2
//  load_pos0  in   5  start position, rotor 0
//  load_pos1  in   5  start position, rotor 1
//  load_pos2  in   5  start position, rotor 2
//  key_valid  in   1  keypress letter available
//  key_in     in   5  keypress letter code 0..25
//  key_ready  out  1  stepper can accept a keypress
//  out_valid  out  1  key_out/pos* valid for the rotor chain
//  out_ready  in   1  rotor chain consumes the current letter
//  key_out    out  5  latched letter, feeds rotor 0 data_in
//  pos0       out  5  rotor 0 position (registered)
//  pos1       out  5  rotor 1 position (registered)
//  pos2       out  5  rotor 2 position (registered)
//  key_err    out  1  1-cycle pulse: accepted keypress had code >= ALPHA, dropped
// BEHAVIOUR
//  Reset: state=IDLE, pos0=pos1=pos2=0, key_out=0, out_valid=0, key_err=0; key_ready=1 after reset.
//  FSM: IDLE -> HOLD on key accept (key_valid & key_ready & key_in<ALPHA); HOLD -> IDLE on out_valid & out_ready.
//  key_ready = (state==IDLE) & ~load. Combinational; no dependence on key_valid.
//  Step on accept, registered, visible the cycle after accept together with out_valid=1:
//   pos0 <= pos0+1 mod 26 (always)
//   pos1 steps if pos0==NOTCH0, or double-step condition (see CONFIGURATION); at most +1 per key
//   pos2 steps if pos1==NOTCH1 (pre-step value)
//   wrap: 25 -> 0; values 26..31 on pos* are unreachable except via load (below).
//  Invalid key (key_in >= 26) while IDLE & key_valid: consumed, no step, state stays IDLE,
//   key_err=1 for exactly one cycle.
//  HOLD: key_out/pos* stable; out_valid held high until out_ready; min throughput 1 key/2 cycles.
//  Load: highest priority, any state. Next cycle: pos* = load_pos* mod 26 (value >=26 loads 0),
//   state=IDLE, out_valid=0; a pending HOLD letter is discarded. Same-cycle key_valid is ignored
//   (key_ready=0 while load).
//  Reset mid-HOLD: out_valid drops asynchronously; positions return to 0.
// CONFIGURATION
//  STEPPER_DOUBLE_STEP_EN defined: historical double-step. Rotor 1 also steps when pos1==NOTCH1,
//   so rotor 1 advances on two consecutive keys around its notch.
//  Not defined: pure odometer. Rotor 1 steps only when pos0==NOTCH0.
// STRUCTURE
//  enigma_pkg: ALPHA=26, letter_t (5-bit) typedef, mod26_inc() function, letter_valid() check.
//  Sub-module rotor_pos_counter: mod-26 register with async rst, load (with clamp) and
//   step enable; instanced 3x. Notch compares and the FSM stay in rotor_stepper.
// TESTING
//  1 Reset then key 'A'(0) -> out_valid next cycle, key_out=0, pos=(2,1,0)=(0,0,1).
//  2 Load (0,3,16), key -> pos2,pos1,pos0=(0,4,17); key -> with _EN (1,5,18); without (0,4,18).
//  3 Load (0,0,25), key -> pos0 wraps to 0, pos1=0 (25!=NOTCH0), pos2=0.
//  4 out_ready=0 for 5 cycles in HOLD -> key_ready=0, outputs frozen; second keypress is not
//    accepted until the cycle after out_ready=1.
//  5 key_in=30 in IDLE -> key_err pulse, pos unchanged, out_valid stays 0.
//  6 Load asserted in HOLD with simultaneous key_valid -> next cycle pos=load values,
//    out_valid=0, key not stepped; load_pos1=28 -> pos1=0.

Source files
------------

// File: rtl/rotor_stepper_pkg.sv
// rotor_stepper_pkg: shared letter type, alphabet size and mod-26 helpers for the stepper
package rotor_stepper_pkg;
  localparam int ALPHA = 26;
  typedef logic [4:0] letter_t;
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic logic letter_valid(letter_t v);
    return v < letter_t'(ALPHA);
  endfunction
  function automatic letter_t mod26_inc(letter_t v);
    return (v >= letter_t'(ALPHA - 1)) ? '0 : v + 5'd1;
  endfunction
  function automatic letter_t clamp(letter_t v);
    return letter_valid(v) ? v : '0;
  endfunction
endpackage

// File: rtl/rotor_stepper_if.sv
// rotor_stepper_if: keypress, load and rotor-chain handshake bundle
interface rotor_stepper_if;
  import rotor_stepper_pkg::*;
  logic    load;
  letter_t load_pos0;
  letter_t load_pos1;
  letter_t load_pos2;
  logic    key_valid;
  letter_t key_in;
  logic    key_ready;
  logic    out_valid;
  logic    out_ready;
  letter_t key_out;
  letter_t pos0;
  letter_t pos1;
  letter_t pos2;
  logic    key_err;
  modport master (
    output load, load_pos0, load_pos1, load_pos2, key_valid, key_in, out_ready,
    input  key_ready, out_valid, key_out, pos0, pos1, pos2, key_err
  );
  modport slave (
    input  load, load_pos0, load_pos1, load_pos2, key_valid, key_in, out_ready,
    output key_ready, out_valid, key_out, pos0, pos1, pos2, key_err
  );
endinterface

// File: rtl/rotor_pos_counter.sv
// rotor_pos_counter: mod-26 rotor position register with clamped load and step enable
module rotor_pos_counter
  import rotor_stepper_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_i,
  input  letter_t load_val_i,
  input  logic    step_i,
  output letter_t pos_o
);
  letter_t pos_q, pos_d;
  // load wins over step; out-of-range load values land on 0
  always_comb pos_d = load_i ? clamp(load_val_i) : step_i ? mod26_inc(pos_q) : pos_q;
  // position register
  always_ff @(posedge clk or posedge rst)
    if (rst) pos_q <= '0;
    else     pos_q <= pos_d;
  assign pos_o = pos_q;
endmodule

// File: rtl/rotor_stepper.sv
// rotor_stepper: keypress stepping controller (odometer with notches); STEPPER_DOUBLE_STEP_EN enables double-step
module rotor_stepper
  import rotor_stepper_pkg::*;
#(
  parameter letter_t NOTCH0 = 5'd16,
  parameter letter_t NOTCH1 = 5'd4
) (
  input logic clk,
  input logic rst,
  rotor_stepper_if.slave bus
);
  state_t  state_q;
  letter_t key_out_q;
  logic    out_valid_q, key_err_q;
  letter_t pos0, pos1, pos2;
  logic    accept, good, bad, kick1, st1, st2;
  assign bus.key_ready = (state_q == IDLE) & ~bus.load;
`ifdef STEPPER_DOUBLE_STEP_EN
  assign kick1 = (pos0 == NOTCH0) | (pos1 == NOTCH1);
`else
  assign kick1 = pos0 == NOTCH0;
`endif
  // accept decode and carry chain; rotor 2 only moves when rotor 1 steps off its notch
  always_comb begin
    accept = bus.key_valid & bus.key_ready;
    good   = accept & letter_valid(bus.key_in);
    bad    = accept & ~letter_valid(bus.key_in);
    st1    = good & kick1;
    st2    = st1 & (pos1 == NOTCH1);
  end
  rotor_pos_counter u_r0 (.clk(clk), .rst(rst), .load_i(bus.load), .load_val_i(bus.load_pos0), .step_i(good), .pos_o(pos0));
  rotor_pos_counter u_r1 (.clk(clk), .rst(rst), .load_i(bus.load), .load_val_i(bus.load_pos1), .step_i(st1), .pos_o(pos1));
  rotor_pos_counter u_r2 (.clk(clk), .rst(rst), .load_i(bus.load), .load_val_i(bus.load_pos2), .step_i(st2), .pos_o(pos2));
  // handshake FSM; load discards any held letter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      key_out_q   <= '0;
      out_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      key_err_q <= bad;
      if (bus.load) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else if (state_q == IDLE && good) begin
        state_q     <= HOLD;
        out_valid_q <= 1'b1;
        key_out_q   <= bus.key_in;
      end else if (state_q == HOLD && bus.out_ready) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end
    end
  assign bus.out_valid = out_valid_q;
  assign bus.key_out   = key_out_q;
  assign bus.key_err   = key_err_q;
  assign bus.pos0      = pos0;
  assign bus.pos1      = pos1;
  assign bus.pos2      = pos2;
endmodule
